// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue.
//
// Generates the PC, issues fetches to a one-cycle-latency instruction memory
// (at most one outstanding), and buffers each returned instruction with its PC
// and PC+PC_INC in a DEPTH-entry FIFO drained by ID over a valid/ready handshake.
// Any nonzero pc_src is a redirect: it reloads the PC, empties the queue and
// discards the in-flight response.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   beq_i, jr_i              branch / register-jump targets (pc_src 01 / 10)
//   pc_4_id_i, offset28_i    jump composition {pc_4_id, offset28} (pc_src 11)
//   pc_src_i                 00 sequential, otherwise redirect this cycle
//   imem_req_o, imem_addr_o  fetch request and address (current PC)
//   imem_rdata_i             instruction, valid the cycle after imem_req_o
//   id_valid_o, id_ready_i   queue head handshake towards ID
//   id_instr_o, id_pc_o, id_pc_4_o  queue head contents
//   q_count_o                queue occupancy
module if_prefetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [XLEN-1:0]        beq_i,
  input  logic [XLEN-1:0]        jr_i,
  input  logic [3:0]             pc_4_id_i,
  input  logic [27:0]            offset28_i,
  input  logic [1:0]             pc_src_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic [XLEN-1:0]        imem_rdata_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [XLEN-1:0]        id_instr_o,
  output logic [XLEN-1:0]        id_pc_o,
  output logic [XLEN-1:0]        id_pc_4_o,
  output logic [$clog2(DEPTH):0] q_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OccW = CntW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic            inflight_q, inflight_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] pc4_mem   [DEPTH];

  logic            redirect;
  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  logic [OccW-1:0] occupancy;

  assign pc_inc    = XLEN'(PC_INC);
  assign redirect  = (pc_src_i != 2'b00);
  // The in-flight fetch already owns a slot, so it counts towards fullness.
  assign occupancy = OccW'(count_q) + OccW'(inflight_q);

  assign issue = rst_ni & ~redirect & (occupancy < OccW'(DEPTH));
  assign push  = inflight_q & ~redirect;
  assign pop   = id_valid_o & id_ready_i;

  always_comb begin
    target = pc_q;
    case (pc_src_i)
      2'b01:   target = beq_i;
      2'b10:   target = jr_i;
      2'b11:   target = XLEN'({pc_4_id_i, offset28_i});
      default: target = pc_q;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = inflight_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (redirect) begin
      pc_d       = target;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d        = pc_q + pc_inc;
        issued_pc_d = pc_q;
      end
      // A response clears the flag unless a new fetch issues on the same edge.
      inflight_d = issue;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      issued_pc_q <= RESET_PC;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= issued_pc_q;
      pc4_mem[wr_ptr_q]   <= issued_pc_q + pc_inc;
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign id_valid_o  = (count_q != '0) & ~redirect;
  assign id_instr_o  = instr_mem[rd_ptr_q];
  assign id_pc_o     = pc_mem[rd_ptr_q];
  assign id_pc_4_o   = pc4_mem[rd_ptr_q];
  assign q_count_o   = count_q;

  // Issue throttling makes this unreachable; catch it if that logic breaks.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(push && (count_q == CntW'(DEPTH))));

endmodule
